// File: rtl/debug_probe_display.sv
// Debug observation unit: selects a probe channel, holds or freezes it,
// and scans it as hex onto a multiplexed seven-segment display plus LEDs.
module debug_probe_display #(
  parameter int NCH     = 16,
  parameter int W       = 32,
  parameter int DIGITS  = 4,
  parameter int REFRESH = 100000,
  localparam int SW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PAGES  = W / (4 * DIGITS),
  localparam int PW     = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int SLICES = W / 16,
  localparam int LW     = (SLICES > 1) ? $clog2(SLICES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*W-1:0]  probes,
  input  logic [SW-1:0]     sel,
  input  logic [PW-1:0]     page,
  input  logic [LW-1:0]     led_sel,
  input  logic              freeze,
  input  logic              capture,
  output logic [15:0]       led,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              frozen
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = $clog2(REFRESH);

  logic [W-1:0]  shown;
  logic [W-1:0]  pick;
  logic [RW-1:0] rcnt;
  logic [DW-1:0] didx;
  logic [15:0]   led_n;
  logic [3:0]    nib;
  logic          nib_ok;
  logic          wrap;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'ha: hex7 = 7'b0001000;
      4'hb: hex7 = 7'b0000011;
      4'hc: hex7 = 7'b1000110;
      4'hd: hex7 = 7'b0100001;
      4'he: hex7 = 7'b0000110;
      4'hf: hex7 = 7'b0001110;
      default: hex7 = 7'b1111111;
    endcase
  endfunction

  // Unmatched select codes fall through to zero
  always_comb begin
    pick = '0;
    for (int k = 0; k < NCH; k++)
      if (sel == SW'(k)) pick = probes[k*W +: W];
  end

  always_comb begin
    led_n = '0;
    for (int k = 0; k < SLICES; k++)
      if (led_sel == LW'(k)) led_n = shown[16*k +: 16];
  end

  // Unmatched page codes leave nib_ok low, blanking the digit
  always_comb begin
    nib    = '0;
    nib_ok = 1'b0;
    for (int p = 0; p < PAGES; p++)
      for (int d = 0; d < DIGITS; d++)
        if (page == PW'(p) && didx == DW'(d)) begin
          nib    = shown[4*(DIGITS*p + d) +: 4];
          nib_ok = 1'b1;
        end
  end

  assign wrap = (rcnt == RW'(REFRESH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shown  <= '0;
      rcnt   <= '0;
      didx   <= '0;
      led    <= '0;
      an     <= '1;
      seg    <= 7'b1111111;
      frozen <= 1'b0;
    end else begin
      if (!freeze || capture) shown <= pick;
      frozen <= freeze;
      led    <= led_n;
      an     <= ~(DIGITS'(1) << didx);
      seg    <= nib_ok ? hex7(nib) : 7'b1111111;
      if (wrap) begin
        rcnt <= '0;
        didx <= (didx == DW'(DIGITS - 1)) ? '0 : didx + 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_debug_probe_display.sv
// Directed bench for debug_probe_display: reset, live scan, pages,
// freeze/capture, invalid select and asynchronous reset mid-scan.
module tb_debug_probe_display;

  localparam int NCH     = 12;
  localparam int W       = 48;
  localparam int DIGITS  = 4;
  localparam int REFRESH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*W-1:0]  probes;
  logic [3:0]        sel;
  logic [1:0]        page;
  logic [1:0]        led_sel;
  logic              freeze;
  logic              capture;
  logic [15:0]       led;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;
  logic              frozen;

  int checks = 0;
  int errors = 0;
  int ec     = 0;

  debug_probe_display #(
    .NCH(NCH), .W(W), .DIGITS(DIGITS), .REFRESH(REFRESH)
  ) dut (
    .clk(clk), .rst(rst), .probes(probes), .sel(sel),
    .page(page), .led_sel(led_sel), .freeze(freeze),
    .capture(capture), .led(led), .an(an), .seg(seg),
    .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ec++;
  endtask

  function automatic int didx_of(input int e);
    return ((e - 1) / REFRESH) % DIGITS;
  endfunction

  function automatic logic [3:0] an_of(input int e);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << didx_of(e));
  endfunction

  task automatic set_ch(input int k, input logic [W-1:0] v);
    probes[k*W +: W] = v;
  endtask

  // tab holds the expected segment code for digit d at [7*d +: 7]
  task automatic scan(input string tag, input logic [15:0] exp_led,
                      input logic [27:0] tab, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s_an%0d", tag, ec), an, an_of(ec));
      chk($sformatf("%s_seg%0d", tag, ec), seg, tab[7*didx_of(ec) +: 7]);
      chk($sformatf("%s_led%0d", tag, ec), led, exp_led);
    end
  endtask

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] SB = 7'b1111111;

  initial begin
    rst     = 1'b0;
    sel     = 4'd3;
    page    = 2'd0;
    led_sel = 2'd0;
    freeze  = 1'b0;
    capture = 1'b0;
    for (int k = 0; k < NCH; k++) set_ch(k, 48'hdead00000000 | 48'(k));
    set_ch(3, 48'h00001234abcd);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", led, 16'h0);
    chk("rst_an", an, 4'hf);
    chk("rst_seg", seg, SB);
    chk("rst_frozen", frozen, 1'b0);

    rst = 1'b1;
    tick();
    chk("first_an", an, 4'he);
    chk("first_seg", seg, S0);
    tick();
    chk("live_led", led, 16'habcd);
    chk("live_seg0", seg, 7'b0100001);
    scan("live", 16'habcd, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 15);

    page    = 2'd1;
    led_sel = 2'd1;
    scan("page1", 16'h1234, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 16);

    page    = 2'd2;
    led_sel = 2'd2;
    scan("page2", 16'h0000, {S0, S0, S0, S0}, 4);

    page    = 2'd3;
    led_sel = 2'd3;
    scan("blank", 16'h0000, {SB, SB, SB, SB}, 8);

    page    = 2'd0;
    led_sel = 2'd0;
    freeze  = 1'b1;
    set_ch(3, 48'hffffffffffff);
    scan("hold", 16'habcd, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4);
    chk("frozen_hi", frozen, 1'b1);

    capture = 1'b1;
    tick();
    capture = 1'b0;
    tick();
    chk("cap_led", led, 16'hffff);
    chk("cap_seg", seg, 7'b0001110);

    freeze = 1'b0;
    set_ch(3, 48'h000000002222);
    tick();
    tick();
    chk("unfreeze_led", led, 16'h2222);
    chk("unfreeze_frozen", frozen, 1'b0);

    freeze  = 1'b1;
    capture = 1'b1;
    set_ch(3, 48'h000000005a5a);
    tick();
    capture = 1'b0;
    set_ch(3, 48'h00000000c3c3);
    tick();
    chk("fcap_led", led, 16'h5a5a);
    tick();
    chk("fcap_hold", led, 16'h5a5a);
    chk("fcap_frozen", frozen, 1'b1);

    freeze = 1'b0;
    sel    = 4'd12;
    tick();
    scan("sel12", 16'h0000, {S0, S0, S0, S0}, 4);
    sel = 4'd15;
    scan("sel15", 16'h0000, {S0, S0, S0, S0}, 4);

    sel = 4'd3;
    set_ch(3, 48'h00001234abcd);
    tick();
    freeze = 1'b1;
    tick();
    for (int i = 0; i < 4 * REFRESH && didx_of(ec) != 2; i++) tick();
    chk("pre_an", an, 4'hb);
    chk("pre_frozen", frozen, 1'b1);

    #2;
    rst = 1'b0;
    #1;
    chk("arst_led", led, 16'h0);
    chk("arst_an", an, 4'hf);
    chk("arst_seg", seg, SB);
    chk("arst_frozen", frozen, 1'b0);
    tick();
    chk("arst_hold_an", an, 4'hf);

    rst    = 1'b1;
    freeze = 1'b0;
    ec     = 0;
    tick();
    chk("resume_an", an, 4'he);
    chk("resume_seg", seg, S0);
    tick();
    chk("resume_led", led, 16'habcd);
    chk("resume_seg1", seg, 7'b0100001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
